dmem_ram: RTL and testbench
===========================

# dmem_ram

Parametrised synchronous data memory for the RISC-V core's load/store path. Replaces the ad-hoc tristate byte RAM with a single-clock, 32-bit-wide, byte-addressed memory that has a valid/ready request handshake, a one-cycle registered response, byte/half/word access with load sign extension, misalignment detection, and an optional post-reset clear sequencer. It sits between the MEM stage and the data-side address space.

## Interface
- ADDR_W, 12: byte-address width; depth = 2^(ADDR_W-2) 32-bit words; legal range 4..20.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting requests; 0 = no clear, ready immediately after reset.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and flagged as an error.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned; the low 8/16/32 bits are used.
- rsp_valid  output  1  response pulse, exactly one cycle per accepted request.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  misaligned access or illegal size; qualified by rsp_valid.
- clearing  output  1  clear sequence in progress.

## Operation
- States: CLEAR, RUN. After reset the block enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- CLEAR:
  - A word counter starts at 0 and writes 32'h0 to word[counter] each cycle.
  - After writing word 2^(ADDR_W-2)-1, the block moves to RUN on the next edge.
  - Total duration is 2^(ADDR_W-2) cycles.
  - clearing=1 and req_ready=0 throughout.
- RUN: req_ready=1 every cycle. There is no backpressure and back-to-back requests are allowed. A request is accepted when req_valid & req_ready.
- Word index = req_addr[ADDR_W-1:2]; lane offset = req_addr[1:0].
- Misaligned cases, which set the error:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - size 11.
  - On error: no memory update, rsp_err=1, rsp_rdata=0.
- Store: write only the addressed lanes.
  - Byte: lane = addr[1:0], data = wdata[7:0].
  - Half: lanes addr[1]*2 and addr[1]*2+1, data = wdata[15:0].
  - Word: all four lanes.
  - Other lanes are preserved.
  - rsp_rdata=0 and rsp_err=0.
- Load: select the addressed byte or half from the stored word and shift it to bit 0. Extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Memory is little-endian: lane 0 is bits [7:0].

## Timing
- Request accepted at edge N. Memory write and response registers update at edge N. rsp_valid is high from edge N to edge N+1, so latency is 1 cycle.
- Back-to-back: requests at consecutive edges produce consecutive rsp_valid pulses, in order.
- Read-after-write: a load at edge N+1 to a word stored at edge N returns the new data.
- No simultaneous-port hazard exists because there is a single port.
- rsp_valid deasserts on the edge after the pulse unless another request is accepted.
- Reset, when rst=1 at an edge:
  - rsp_valid, rsp_err, rsp_rdata and the counter go to 0.
  - clearing goes to CLEAR_ON_RESET.
  - req_ready goes to !CLEAR_ON_RESET.
  - Any request presented in that cycle is discarded with no write.
- Reset mid-CLEAR restarts the counter at 0.
- Reset mid-RUN does not clear memory when CLEAR_ON_RESET=0; contents are retained.
- Memory contents are undefined after power-up when CLEAR_ON_RESET=0.

## Test plan
- Reset with ADDR_W=6, CLEAR_ON_RESET=1 → clearing=1 and req_ready=0 for exactly 16 cycles, then req_ready=1. Loading word at 0x3C returns 0x00000000 with rsp_err=0.
- Store word 0x8899AABB @0x10, then at consecutive edges:
  - load byte @0x11 signed → 0xFFFFFFAA;
  - load byte @0x11 unsigned → 0x000000AA;
  - load half @0x12 signed → 0xFFFF8899.
  - Each response arrives exactly 1 cycle after its request.
- Store word 0x11223344 @0x20, store byte 0xEE @0x22, store half 0x5566 @0x20 → word load @0x20 returns 0x11EE5566.
- Misaligned checks:
  - store word 0xDEADBEEF @0x21 → rsp_err=1, and a later word load @0x20 is unchanged;
  - half load @0x23 → rsp_err=1, rdata=0;
  - size 11 → rsp_err=1.
- Assert rst for 1 cycle midway through CLEAR (counter=7) → the clear restarts and lasts a full 16 cycles from the reset edge. A request held valid during CLEAR produces no rsp_valid.
- With CLEAR_ON_RESET=0: store 0x12345678 @0x8, pulse rst, then load @0x8 → req_ready=1 on the first cycle after reset, and the load returns 0x12345678.

Source files
------------

// File: rtl/dmem_ram_if.sv
`default_nettype none
// ============================================================================
// dmem_ram_if : request/response bundle for the dmem_ram data memory
// Revision    : 1.0
// ============================================================================
interface dmem_ram_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              clearing;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, clearing
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, clearing
    );
endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// dmem_ram : single-port byte-addressed data memory, 1-cycle registered reply
// Revision : 1.0
// ============================================================================
module dmem_ram #(
    parameter int ADDR_W         = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    dmem_ram_if.slave bus
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [31:0]      mem_q [DEPTH];

    logic             w_ready;
    logic             w_accept;
    logic             w_mis;
    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_wr_en;
    logic [3:0]       w_wr_be;
    logic [IDX_W-1:0] w_wr_idx;
    logic [31:0]      w_wr_data;
    logic [31:0]      w_rd_shift;
    logic [31:0]      w_ld_data;

    assign w_ready  = (state_q == ST_RUN);
    assign w_accept = bus.req_valid & w_ready;
    assign w_off    = bus.req_addr[1:0];
    assign w_idx    = bus.req_addr[ADDR_W-1:2];

    always_comb begin
        w_mis = 1'b0;
        case (bus.req_size)
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = w_off[0];
            2'b10:   w_mis = |w_off;
            default: w_mis = 1'b1;
        endcase
    end

    // The clear sequencer owns the write port while in CLEAR
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_be   = 4'b0000;
        w_wr_idx  = w_idx;
        w_wr_data = bus.req_wdata;
        if (state_q == ST_CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_be   = 4'b1111;
            w_wr_idx  = cnt_q;
            w_wr_data = 32'h0;
        end else if (w_accept && bus.req_we && !w_mis) begin
            w_wr_en = 1'b1;
            case (bus.req_size)
                2'b00: begin
                    w_wr_be   = 4'b0001 << w_off;
                    w_wr_data = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    w_wr_be   = w_off[1] ? 4'b1100 : 4'b0011;
                    w_wr_data = {2{bus.req_wdata[15:0]}};
                end
                default: w_wr_be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b]) begin
                    mem_q[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_shift = mem_q[w_idx] >> {w_off, 3'b000};

    always_comb begin
        w_ld_data = w_rd_shift;
        case (bus.req_size)
            2'b00: w_ld_data = bus.req_unsigned ? {24'h0, w_rd_shift[7:0]}
                                                : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            2'b01: w_ld_data = bus.req_unsigned ? {16'h0, w_rd_shift[15:0]}
                                                : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_ld_data = w_rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = w_accept;
        rsp_err_d   = w_accept & w_mis;
        rsp_rdata_d = (w_accept && !bus.req_we && !w_mis) ? w_ld_data : 32'h0;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {IDX_W{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  cnt_d   = '0;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.clearing  = (state_q == ST_CLEAR);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_ram.sv
`default_nettype none
// ============================================================================
// tb_dmem_ram : scoreboard bench for dmem_ram (clearing and non-clearing builds)
// Revision    : 1.0
// ============================================================================
module tb_dmem_ram;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    dmem_ram_if #(.ADDR_W(6)) bus0 ();
    dmem_ram_if #(.ADDR_W(6)) bus1 ();

    dmem_ram #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.slave)
    );

    dmem_ram #(.ADDR_W(6), .CLEAR_ON_RESET(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Response monitors: pop the oldest expectation whenever a response appears
    always @(negedge clk) begin
        if (bus0.rsp_valid === 1'b1) begin
            n_chk++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL dut0_unexpected_rsp: got rdata %h err %b at cycle %0d, want no response",
                         bus0.rsp_rdata, bus0.rsp_err, cyc);
            end else begin
                e0 = q0.pop_front();
                if (bus0.rsp_rdata !== e0.rdata || bus0.rsp_err !== e0.err || cyc != e0.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got rdata %h err %b cyc %0d, want rdata %h err %b cyc %0d",
                             e0.nm, bus0.rsp_rdata, bus0.rsp_err, cyc, e0.rdata, e0.err, e0.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.rsp_valid === 1'b1) begin
            n_chk++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_unexpected_rsp: got rdata %h err %b at cycle %0d, want no response",
                         bus1.rsp_rdata, bus1.rsp_err, cyc);
            end else begin
                e1 = q1.pop_front();
                if (bus1.rsp_rdata !== e1.rdata || bus1.rsp_err !== e1.err || cyc != e1.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got rdata %h err %b cyc %0d, want rdata %h err %b cyc %0d",
                             e1.nm, bus1.rsp_rdata, bus1.rsp_err, cyc, e1.rdata, e1.err, e1.cyc);
                end
            end
        end
    end

    // Drive one request at the next falling edge; it is accepted at the following rising edge
    task automatic issue(input bit sel, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [5:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input bit ee, input string nm);
        exp_t e;
        @(negedge clk);
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + 1;
        e.nm    = nm;
        if (!sel) begin
            bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_size = sz;
            bus0.req_unsigned = uns; bus0.req_addr = a; bus0.req_wdata = wd;
            q0.push_back(e);
        end else begin
            bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_size = sz;
            bus1.req_unsigned = uns; bus1.req_addr = a; bus1.req_wdata = wd;
            q1.push_back(e);
        end
    endtask

    task automatic idle(input bit sel);
        @(negedge clk);
        if (!sel) bus0.req_valid = 1'b0;
        else      bus1.req_valid = 1'b0;
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        while (((sel ? q1.size() : q0.size()) != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(sel ? "dut1_drain" : "dut0_drain", 32'(sel ? q1.size() : q0.size()), 32'd0);
    endtask

    // Starts at the falling edge right after the reset edge; returns cycles spent clearing
    task automatic count_clear(output int n);
        n = 0;
        while (bus0.clearing === 1'b1 && n < 100) begin
            if (bus0.req_ready !== 1'b0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ready_during_clear: got %b want 0", bus0.req_ready);
            end
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_size = 2'b00;
        bus0.req_unsigned = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_size = 2'b00;
        bus1.req_unsigned = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

        // Power-up clear
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        chk("reset_clearing", 32'(bus0.clearing), 32'd1);
        chk("reset_ready", 32'(bus0.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        count_clear(n);
        chk("clear_cycles", n, 32'd16);
        chk("ready_after_clear", 32'(bus0.req_ready), 32'd1);

        issue(0, 0, 2'b10, 0, 6'h3C, 32'h0, 32'h0000_0000, 0, "ld_w_3c_cleared");

        // Store then loads at consecutive edges
        issue(0, 1, 2'b10, 0, 6'h10, 32'h8899_AABB, 32'h0, 0, "st_w_10");
        issue(0, 0, 2'b00, 0, 6'h11, 32'h0, 32'hFFFF_FFAA, 0, "ld_b_11_s");
        issue(0, 0, 2'b00, 1, 6'h11, 32'h0, 32'h0000_00AA, 0, "ld_b_11_u");
        issue(0, 0, 2'b01, 0, 6'h12, 32'h0, 32'hFFFF_8899, 0, "ld_h_12_s");
        issue(0, 0, 2'b01, 1, 6'h10, 32'h0, 32'h0000_AABB, 0, "ld_h_10_u");

        // Partial-lane merges
        issue(0, 1, 2'b10, 0, 6'h20, 32'h1122_3344, 32'h0, 0, "st_w_20");
        issue(0, 1, 2'b00, 0, 6'h22, 32'hFFFF_FFEE, 32'h0, 0, "st_b_22");
        issue(0, 1, 2'b01, 0, 6'h20, 32'hABCD_5566, 32'h0, 0, "st_h_20");
        issue(0, 0, 2'b10, 1, 6'h20, 32'h0, 32'h11EE_5566, 0, "ld_w_20_merge");
        issue(0, 0, 2'b01, 1, 6'h22, 32'h0, 32'h0000_11EE, 0, "ld_h_22_u");
        issue(0, 0, 2'b00, 0, 6'h22, 32'h0, 32'hFFFF_FFEE, 0, "ld_b_22_s");
        issue(0, 0, 2'b00, 0, 6'h23, 32'h0, 32'h0000_0011, 0, "ld_b_23_s");

        // Misaligned and illegal-size requests
        issue(0, 1, 2'b10, 0, 6'h21, 32'hDEAD_BEEF, 32'h0, 1, "st_w_21_mis");
        issue(0, 0, 2'b10, 0, 6'h20, 32'h0, 32'h11EE_5566, 0, "ld_w_20_unchanged");
        issue(0, 0, 2'b01, 0, 6'h23, 32'h0, 32'h0, 1, "ld_h_23_mis");
        issue(0, 0, 2'b11, 0, 6'h20, 32'h0, 32'h0, 1, "ld_size11");
        issue(0, 1, 2'b01, 0, 6'h11, 32'h0000_7777, 32'h0, 1, "st_h_11_mis");
        issue(0, 0, 2'b10, 0, 6'h10, 32'h0, 32'h8899_AABB, 0, "ld_w_10_unchanged");
        idle(0);
        drain(0);

        // Reset mid-clear restarts the full sweep; held request must not be taken
        rst0 = 1'b1;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_size = 2'b10;
        bus0.req_addr = 6'h04; bus0.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (7) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        count_clear(n);
        bus0.req_valid = 1'b0;
        chk("clear_restart_cycles", n, 32'd16);
        chk("ready_after_restart", 32'(bus0.req_ready), 32'd1);
        issue(0, 0, 2'b10, 0, 6'h10, 32'h0, 32'h0, 0, "ld_w_10_recleared");
        issue(0, 0, 2'b10, 0, 6'h04, 32'h0, 32'h0, 0, "ld_w_04_no_store");
        idle(0);
        drain(0);

        // Non-clearing build retains contents across reset
        rst1 = 1'b0;
        chk("nc_reset_ready", 32'(bus1.req_ready), 32'd1);
        chk("nc_reset_clearing", 32'(bus1.clearing), 32'd0);
        issue(1, 1, 2'b10, 0, 6'h08, 32'h1234_5678, 32'h0, 0, "nc_st_w_08");
        idle(1);
        drain(1);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("nc_ready_after_rst", 32'(bus1.req_ready), 32'd1);
        issue(1, 0, 2'b10, 0, 6'h08, 32'h0, 32'h1234_5678, 0, "nc_ld_w_08_retained");
        issue(1, 0, 2'b00, 1, 6'h0B, 32'h0, 32'h0000_0012, 0, "nc_ld_b_0b_u");
        idle(1);
        drain(1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
